botao_cond: RTL

BOTAO_COND -- requirements
Module: botao_cond

---
 rtl/botao_cond.sv | 118 +++++++++++
 1 files changed

// File: rtl/botao_cond.sv
// Pedestrian button conditioner: synchronizes and debounces a raw button, then
// runs an IDLE/PENDING/COOLDOWN handshake that drives the semaforo bt input.
module botao_cond #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       ack,
  output logic       bt,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_PENDING  = 2'b01,
    S_COOLDOWN = 2'b10,
    S_ILLEGAL  = 2'b11
  } state_e;

  localparam logic [7:0] DB_LAST      = 8'(DEBOUNCE - 1);
  localparam logic [7:0] CD_LAST      = 8'(COOLDOWN - 1);
  localparam bit         HAS_COOLDOWN = (COOLDOWN != 0);

  logic       s1_q, s2_q;
  logic       btn_s;
  logic       btn_db_q, btn_db_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press;

  state_e     state_q, state_d;
  logic [7:0] ccnt_q, ccnt_d;
  logic       bt_q, bt_d;

  assign btn_s = s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      btn_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      btn_db_q <= btn_db_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    btn_db_d = btn_db_q;
    cnt_d    = cnt_q;
    if (btn_s == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Rising acceptance of the debounced level; a held button yields it only once.
  assign press = btn_s & ~btn_db_q & (cnt_q == DB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ccnt_q  <= '0;
      bt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
      bt_q    <= bt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_PENDING;
      end
      S_PENDING: begin
        // ack takes priority; a press arriving on the same edge is dropped
        if (ack) begin
          if (HAS_COOLDOWN) begin
            state_d = S_COOLDOWN;
            ccnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_COOLDOWN: begin
        ccnt_d = ccnt_q + 8'd1;
        if (ccnt_q == CD_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bt is registered from the next state so it moves together with estado.
  always_comb begin
    bt_d = (state_d == S_PENDING);
  end

  assign bt     = bt_q;
  assign estado = state_q;

endmodule
